// File: rtl/param_sync_fifo_pkg.sv
// Shared types and defaults for the parameterised synchronous FIFO.
// Holds the status bundle and the pointer-width helper.
package fifo_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 16;
   localparam int unsigned DEF_FIFO_DEPTH = 8;

   typedef struct packed {
      logic full;
      logic empty;
      logic almostfull;
      logic almostempty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Producer/consumer bus of param_sync_fifo: write side, read side,
// thresholds and status. The master drives requests; the slave is the FIFO.
interface param_sync_fifo_if
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
);
   localparam int unsigned AW = ptr_width(FIFO_DEPTH);

   logic                  flush;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  rd_en;
   logic [AW:0]           af_thresh;
   logic [AW:0]           ae_thresh;
   logic                  sticky_clr;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  rd_valid;
   logic                  wr_ack;
   logic                  overflow;
   logic                  underflow;
   logic                  full;
   logic                  empty;
   logic                  almostfull;
   logic                  almostempty;
   logic [AW:0]           level;
   logic                  ovf_sticky;
   logic                  udf_sticky;

   modport master (
      output flush, wr_en, data_in, rd_en, af_thresh, ae_thresh, sticky_clr,
      input  data_out, rd_valid, wr_ack, overflow, underflow, full, empty,
             almostfull, almostempty, level, ovf_sticky, udf_sticky
   );

   modport slave (
      input  flush, wr_en, data_in, rd_en, af_thresh, ae_thresh, sticky_clr,
      output data_out, rd_valid, wr_ack, overflow, underflow, full, empty,
             almostfull, almostempty, level, ovf_sticky, udf_sticky
   );

endinterface

// File: rtl/param_sync_fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int unsigned AW         = ptr_width(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with thresholds, flush, occupancy, sticky errors and a
// selectable registered or first-word-fall-through read path.
module param_sync_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter bit          FWFT       = 1'b0
) (
   input logic             clk,
   input logic             rst_n,
   param_sync_fifo_if.slave bus
);

   localparam int unsigned AW        = ptr_width(FIFO_DEPTH);
   localparam logic [AW:0]   DEPTH_LVL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   LVL_ONE   = 1;
   localparam logic [AW-1:0] PTR_ONE   = 1;

   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           level_q;
   logic                  wr_acc, rd_acc, ovf_ev, udf_ev;
   logic                  wr_ack_q, ovf_q, udf_q, ovf_sticky_q, udf_sticky_q;
   logic [DATA_WIDTH-1:0] rdata;
   fifo_status_t          status;

   always_comb begin
      status             = '0;
      status.full        = (level_q == DEPTH_LVL);
      status.empty       = (level_q == '0);
      status.almostfull  = (level_q >= bus.af_thresh);
      status.almostempty = (level_q <= bus.ae_thresh);
      status.overflow    = ovf_q;
      status.underflow   = udf_q;
   end

   // Flush masks the requests so it also suppresses error pulses and memory writes.
   assign wr_acc = bus.wr_en & ~status.full  & ~bus.flush;
   assign rd_acc = bus.rd_en & ~status.empty & ~bus.flush;
   assign ovf_ev = bus.wr_en &  status.full  & ~bus.flush;
   assign udf_ev = bus.rd_en &  status.empty & ~bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level_q  <= '0;
         wr_ack_q <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level_q  <= '0;
         wr_ack_q <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
         unique case ({wr_acc, rd_acc})
            2'b10:   level_q <= level_q + LVL_ONE;
            2'b01:   level_q <= level_q - LVL_ONE;
            default: level_q <= level_q;
         endcase
         wr_ack_q <= wr_acc;
         ovf_q    <= ovf_ev;
         udf_q    <= udf_ev;
      end
   end

   // Set beats clear; flush leaves the sticky history untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky_q <= 1'b0;
         udf_sticky_q <= 1'b0;
      end else begin
         if (ovf_ev)              ovf_sticky_q <= 1'b1;
         else if (bus.sticky_clr) ovf_sticky_q <= 1'b0;
         if (udf_ev)              udf_sticky_q <= 1'b1;
         else if (bus.sticky_clr) udf_sticky_q <= 1'b0;
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .AW         (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (bus.data_in),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   generate
      if (FWFT) begin : g_fwft
         assign bus.data_out = rdata;
         assign bus.rd_valid = ~status.empty;
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] dout_q;
         logic                  rvalid_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dout_q   <= '0;
               rvalid_q <= 1'b0;
            end else if (bus.flush) begin
               dout_q   <= '0;
               rvalid_q <= 1'b0;
            end else begin
               if (rd_acc) dout_q <= rdata;
               rvalid_q <= rd_acc;
            end
         end

         assign bus.data_out = dout_q;
         assign bus.rd_valid = rvalid_q;
      end
   endgenerate

   assign bus.wr_ack      = wr_ack_q;
   assign bus.overflow    = status.overflow;
   assign bus.underflow   = status.underflow;
   assign bus.full        = status.full;
   assign bus.empty       = status.empty;
   assign bus.almostfull  = status.almostfull;
   assign bus.almostempty = status.almostempty;
   assign bus.level       = level_q;
   assign bus.ovf_sticky  = ovf_sticky_q;
   assign bus.udf_sticky  = udf_sticky_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: registered-read and FWFT instances,
// a vector table for fill/drain/error cases and a data scoreboard.
module tb_param_sync_fifo;

   logic clk;
   logic rst_n;

   param_sync_fifo_if #(.DATA_WIDTH(16), .FIFO_DEPTH(8)) if0 ();
   param_sync_fifo_if #(.DATA_WIDTH(16), .FIFO_DEPTH(8)) if1 ();

   param_sync_fifo #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0));
   param_sync_fifo #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr, rd, sclr;
      logic [15:0] data;
      int          lvl;
      logic        ack, ovf, udf, full, empty, os, us;
   } vec_t;

   vec_t        vec [20];
   logic [15:0] sb [$];
   int          mlevel;
   logic        mos, mus;
   int          checks;
   int          failures;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock of the registered-read instance, with model and scoreboard.
   task automatic cyc0(input logic wr, input logic rd, input logic [15:0] d,
                       input logic fl, input logic sc);
      logic        wacc, racc, oe, ue;
      logic [15:0] exp_d;
      if0.wr_en = wr; if0.rd_en = rd; if0.data_in = d;
      if0.flush = fl; if0.sticky_clr = sc;
      wacc  = wr && !fl && (mlevel != 8);
      racc  = rd && !fl && (mlevel != 0);
      oe    = wr && !fl && (mlevel == 8);
      ue    = rd && !fl && (mlevel == 0);
      exp_d = '0;
      if (racc) exp_d = sb.pop_front();
      if (wacc) sb.push_back(d);
      if (fl) sb.delete();
      @(posedge clk); #1;
      mlevel = fl ? 0 : mlevel + int'(wacc) - int'(racc);
      mos = oe ? 1'b1 : (sc ? 1'b0 : mos);
      mus = ue ? 1'b1 : (sc ? 1'b0 : mus);
      if0.wr_en = 1'b0; if0.rd_en = 1'b0; if0.flush = 1'b0; if0.sticky_clr = 1'b0;
      chk("level", if0.level, mlevel);
      chk("wr_ack", if0.wr_ack, wacc);
      chk("overflow", if0.overflow, oe);
      chk("underflow", if0.underflow, ue);
      chk("ovf_sticky", if0.ovf_sticky, mos);
      chk("udf_sticky", if0.udf_sticky, mus);
      chk("rd_valid", if0.rd_valid, racc);
      if (racc) chk("rd_data", if0.data_out, exp_d);
      if (fl) chk("flush_dout", if0.data_out, 0);
   endtask

   initial begin
      checks = 0; failures = 0; mlevel = 0; mos = 1'b0; mus = 1'b0;
      rst_n = 1'b0;
      if0.flush = 0; if0.wr_en = 0; if0.rd_en = 0; if0.data_in = '0;
      if0.sticky_clr = 0; if0.af_thresh = 4'd6; if0.ae_thresh = 4'd2;
      if1.flush = 0; if1.wr_en = 0; if1.rd_en = 0; if1.data_in = '0;
      if1.sticky_clr = 0; if1.af_thresh = 4'd6; if1.ae_thresh = 4'd2;

      // Fill 1..8, overflow, full-simultaneous, drain, empty-simultaneous, clear.
      for (int i = 0; i < 8; i++)
         vec[i] = '{1, 0, 0, 16'(i + 1), i + 1, 1, 0, 0, (i == 7), 0, 0, 0};
      vec[8]  = '{1, 0, 0, 16'h0009, 8, 0, 1, 0, 1, 0, 1, 0};
      vec[9]  = '{1, 1, 0, 16'h00AA, 7, 0, 1, 0, 0, 0, 1, 0};
      for (int i = 10; i < 17; i++)
         vec[i] = '{0, 1, 0, 16'h0000, 16 - i, 0, 0, 0, 0, (i == 16), 1, 0};
      vec[17] = '{1, 1, 0, 16'hABCD, 1, 1, 0, 1, 0, 0, 1, 1};
      vec[18] = '{0, 0, 1, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0};
      vec[19] = '{0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0};

      #3;
      chk("rst_level", if0.level, 0);
      chk("rst_empty", if0.empty, 1);
      chk("rst_full", if0.full, 0);
      chk("rst_wr_ack", if0.wr_ack, 0);
      chk("rst_rd_valid", if0.rd_valid, 0);
      chk("rst_data_out", if0.data_out, 0);
      chk("rst_sticky", {if0.ovf_sticky, if0.udf_sticky}, 0);
      chk("rst_fwft_valid", if1.rd_valid, 0);
      #9 rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vec[i]) begin
         cyc0(vec[i].wr, vec[i].rd, vec[i].data, 1'b0, vec[i].sclr);
         chk($sformatf("vec%0d_level", i), if0.level, vec[i].lvl);
         chk($sformatf("vec%0d_ack", i), if0.wr_ack, vec[i].ack);
         chk($sformatf("vec%0d_ovf", i), if0.overflow, vec[i].ovf);
         chk($sformatf("vec%0d_udf", i), if0.underflow, vec[i].udf);
         chk($sformatf("vec%0d_full", i), if0.full, vec[i].full);
         chk($sformatf("vec%0d_empty", i), if0.empty, vec[i].empty);
         chk($sformatf("vec%0d_osticky", i), if0.ovf_sticky, vec[i].os);
         chk($sformatf("vec%0d_usticky", i), if0.udf_sticky, vec[i].us);
      end

      // Threshold sweep: fill then drain with af=6, ae=2.
      for (int l = 0; l <= 8; l++) begin
         chk($sformatf("ae_fill%0d", l), if0.almostempty, (l <= 2));
         chk($sformatf("af_fill%0d", l), if0.almostfull, (l >= 6));
         if (l < 8) cyc0(1'b1, 1'b0, 16'(16'h100 + l), 1'b0, 1'b0);
      end
      for (int l = 7; l >= 0; l--) begin
         cyc0(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
         chk($sformatf("ae_drain%0d", l), if0.almostempty, (l <= 2));
         chk($sformatf("af_drain%0d", l), if0.almostfull, (l >= 6));
      end
      if0.af_thresh = 4'd0; if0.ae_thresh = 4'd8; #1;
      chk("af_zero_at_empty", if0.almostfull, 1);
      for (int l = 0; l < 8; l++) cyc0(1'b1, 1'b0, 16'(16'h200 + l), 1'b0, 1'b0);
      chk("ae_max_at_full", if0.almostempty, 1);
      for (int l = 0; l < 8; l++) cyc0(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
      if0.af_thresh = 4'd6; if0.ae_thresh = 4'd2;

      // FWFT instance.
      if1.wr_en = 1; if1.data_in = 16'h1111;
      @(posedge clk); #1;
      if1.data_in = 16'h2222;
      chk("fwft_ack1", if1.wr_ack, 1);
      chk("fwft_valid1", if1.rd_valid, 1);
      chk("fwft_data1", if1.data_out, 16'h1111);
      @(posedge clk); #1;
      if1.wr_en = 0; if1.rd_en = 1;
      chk("fwft_hold", if1.data_out, 16'h1111);
      chk("fwft_level2", if1.level, 2);
      @(posedge clk); #1;
      chk("fwft_data2", if1.data_out, 16'h2222);
      chk("fwft_valid2", if1.rd_valid, 1);
      @(posedge clk); #1;
      if1.rd_en = 0;
      chk("fwft_valid_end", if1.rd_valid, 0);
      chk("fwft_empty_end", if1.empty, 1);

      // Level 5, wrap with mixed ops, flush with a write pending, then reset mid-burst.
      for (int i = 0; i < 5; i++) cyc0(1'b1, 1'b0, 16'(16'h300 + i), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++)
         cyc0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              16'($urandom), 1'b0, 1'b0);
      cyc0(1'b1, 1'b0, 16'hDEAD, 1'b1, 1'b0);
      chk("flush_level", if0.level, 0);
      chk("flush_empty", if0.empty, 1);
      for (int i = 0; i < 3; i++) cyc0(1'b1, 1'b0, 16'(16'h400 + i), 1'b0, 1'b0);
      cyc0(1'b1, 1'b1, 16'h0403, 1'b0, 1'b0);
      if0.wr_en = 1; if0.rd_en = 1; if0.data_in = 16'h0404;
      #1 rst_n = 1'b0;
      #1;
      chk("arst_level", if0.level, 0);
      chk("arst_empty", if0.empty, 1);
      chk("arst_wr_ack", if0.wr_ack, 0);
      chk("arst_rd_valid", if0.rd_valid, 0);
      chk("arst_data_out", if0.data_out, 0);
      chk("arst_flags", {if0.overflow, if0.underflow, if0.ovf_sticky, if0.udf_sticky}, 0);
      mlevel = 0; mos = 1'b0; mus = 1'b0; sb.delete();
      #1 rst_n = 1'b1;
      cyc0(1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0);
      chk("post_rst_udf", if0.underflow, 1);
      cyc0(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
